// File: rtl/bus_arb.sv
// Two-port round-robin arbiter that sequences 1/2/4/8-byte little-endian
// transfers onto a single 8-bit bus unit, with a per-byte timeout.
module bus_arb #(
    parameter int ADDR_W  = 17,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [1:0]        m0_size,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [63:0]       m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    output logic [63:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [1:0]        m1_size,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [63:0]       m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [63:0]       m1_rdata,
    output logic              bus_valid,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ready,
    output logic              gnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_DONE
    } state_t;

    state_t            state_q;
    logic              last_q;
    logic              gnt_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] base_q;
    logic [63:0]       wdata_q;
    logic [2:0]        idx_q;
    logic [63:0]       res_q;
    logic [TO_W-1:0]   cnt_q;
    logic              err_q;

    logic              bus_valid_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [7:0]        bus_wdata_q;
    logic              m0_done_q;
    logic              m0_err_q;
    logic [63:0]       m0_rdata_q;
    logic              m1_done_q;
    logic              m1_err_q;
    logic [63:0]       m1_rdata_q;

    logic              sel_d;
    logic              g_we;
    logic [1:0]        g_size;
    logic [ADDR_W-1:0] g_addr;
    logic [63:0]       g_wdata;
    logic [2:0]        idx_nx;
    logic [2:0]        last_idx;
    logic [63:0]       res_mask;
    logic [63:0]       fin_rdata;
    logic              to_hit;

    // Both requesting: the port that did not win last time goes next.
    assign sel_d   = (m0_req & m1_req) ? ~last_q : m1_req;
    assign g_we    = sel_d ? m1_we    : m0_we;
    assign g_size  = sel_d ? m1_size  : m0_size;
    assign g_addr  = sel_d ? m1_addr  : m0_addr;
    assign g_wdata = sel_d ? m1_wdata : m0_wdata;

    assign idx_nx   = idx_q + 3'd1;
    assign last_idx = 3'((4'd1 << size_q) - 4'd1);
    assign to_hit   = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

    always_comb begin
        res_mask = 64'h0;
        unique case (size_q)
            2'd0: res_mask = 64'h0000_0000_0000_00FF;
            2'd1: res_mask = 64'h0000_0000_0000_FFFF;
            2'd2: res_mask = 64'h0000_0000_FFFF_FFFF;
            2'd3: res_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    assign fin_rdata = (err_q | we_q) ? 64'h0 : (res_q & res_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= 2'd0;
            base_q      <= '0;
            wdata_q     <= 64'h0;
            idx_q       <= 3'd0;
            res_q       <= 64'h0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 8'h0;
            m0_done_q   <= 1'b0;
            m0_err_q    <= 1'b0;
            m0_rdata_q  <= 64'h0;
            m1_done_q   <= 1'b0;
            m1_err_q    <= 1'b0;
            m1_rdata_q  <= 64'h0;
        end else begin
            m0_done_q <= 1'b0;
            m0_err_q  <= 1'b0;
            m1_done_q <= 1'b0;
            m1_err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (m0_req | m1_req) begin
                        gnt_q       <= sel_d;
                        last_q      <= sel_d;
                        we_q        <= g_we;
                        size_q      <= g_size;
                        base_q      <= g_addr;
                        wdata_q     <= g_wdata;
                        idx_q       <= 3'd0;
                        res_q       <= 64'h0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        bus_valid_q <= 1'b1;
                        bus_we_q    <= g_we;
                        bus_addr_q  <= g_addr;
                        bus_wdata_q <= g_wdata[7:0];
                        state_q     <= S_XFER;
                    end
                end
                S_XFER: begin
                    if (bus_ready) begin
                        cnt_q <= '0;
                        if (!we_q) begin
                            res_q[{idx_q, 3'b000} +: 8] <= bus_rdata;
                        end
                        if (idx_q == last_idx) begin
                            bus_valid_q <= 1'b0;
                            state_q     <= S_DONE;
                        end else begin
                            idx_q       <= idx_nx;
                            bus_addr_q  <= base_q + ADDR_W'(idx_nx);
                            bus_wdata_q <= wdata_q[{idx_nx, 3'b000} +: 8];
                        end
                    end else if (to_hit) begin
                        bus_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    // Bus is idle here; result is masked into the owner's rdata.
                    if (gnt_q) begin
                        m1_done_q  <= 1'b1;
                        m1_err_q   <= err_q;
                        m1_rdata_q <= fin_rdata;
                    end else begin
                        m0_done_q  <= 1'b1;
                        m0_err_q   <= err_q;
                        m0_rdata_q <= fin_rdata;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign m0_done   = m0_done_q;
    assign m0_err    = m0_err_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_done   = m1_done_q;
    assign m1_err    = m1_err_q;
    assign m1_rdata  = m1_rdata_q;
    assign gnt       = gnt_q;

endmodule

// File: tb/tb_bus_arb.sv
// Scoreboard bench for bus_arb: directed requests push expected bus beats
// and completions; negedge monitors pop and compare.
module tb_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [1:0]  m0_size = 2'd0;
    logic [16:0] m0_addr = '0;
    logic [63:0] m0_wdata = '0;
    logic        m0_done, m0_err;
    logic [63:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [1:0]  m1_size = 2'd0;
    logic [16:0] m1_addr = '0;
    logic [63:0] m1_wdata = '0;
    logic        m1_done, m1_err;
    logic [63:0] m1_rdata;
    logic        bus_valid, bus_we;
    logic [16:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = 8'h0;
    logic        bus_ready = 1'b0;
    logic        gnt;

    bus_arb #(.ADDR_W(17), .TIMEOUT(4), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ready(bus_ready), .gnt(gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [16:0] addr;
        logic        we;
        logic [7:0]  wd;
    } beat_t;

    exp_t       exp_q[$];
    beat_t      beat_q[$];
    logic [7:0] rd_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wait_n = 0;
    bit         stuck = 1'b0;
    int         bv_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void push_exp(int port, logic err, logic [63:0] rd, int c);
        exp_t e;
        e.port = port; e.err = err; e.rdata = rd; e.cyc = c;
        exp_q.push_back(e);
    endfunction

    function automatic void push_beat(logic [16:0] a, logic we, logic [7:0] wd);
        beat_t b;
        b.addr = a; b.we = we; b.wd = wd;
        beat_q.push_back(b);
    endfunction

    // Bus unit model: wait_n low cycles then one ready cycle per byte.
    initial begin
        int wcnt;
        wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (bus_valid && !stuck) begin
                if (wcnt < wait_n) begin
                    bus_ready = 1'b0;
                    wcnt++;
                end else begin
                    bus_ready = 1'b1;
                    bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
                    wcnt = 0;
                end
            end else begin
                bus_ready = 1'b0;
                wcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_valid) bv_cnt++;
            if (bus_valid && bus_ready) begin
                beat_t b;
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", {47'h0, bus_addr}, 64'h1FFFFFF);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_addr", {47'h0, bus_addr}, {47'h0, b.addr});
                    chk("beat_we", {63'h0, bus_we}, {63'h0, b.we});
                    if (b.we) chk("beat_wdata", {56'h0, bus_wdata}, {56'h0, b.wd});
                end
            end
            if (m0_done || m1_done) begin
                exp_t e;
                int   p;
                p = m1_done ? 1 : 0;
                chk("done_exclusive", {63'h0, m0_done & m1_done}, 64'h0);
                if (exp_q.size() == 0) begin
                    chk("spurious_done_port", p, 64'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_port", p, e.port);
                    chk("gnt", {63'h0, gnt}, e.port);
                    chk("err", {63'h0, (p ? m1_err : m0_err)}, {63'h0, e.err});
                    chk("rdata", p ? m1_rdata : m0_rdata, e.rdata);
                    if (e.cyc >= 0) chk("done_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_req(input int port, input logic we, input logic [1:0] sz,
                          input logic [16:0] a, input logic [63:0] wd);
        bit got;
        got = 1'b0;
        if (port == 0) begin
            m0_we = we; m0_size = sz; m0_addr = a; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_size = sz; m1_addr = a; m1_wdata = wd; m1_req = 1'b1;
        end
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            got = (port == 0) ? m0_done : m1_done;
        end
        if (port == 0) m0_req = 1'b0;
        else m1_req = 1'b0;
        chk("req_completed", {63'h0, got}, 64'h1);
    endtask

    task automatic contend(input logic [7:0] b0, input logic [7:0] b1);
        @(posedge clk); #1;
        rd_q.push_back(b0);
        rd_q.push_back(b1);
        push_beat(17'h00040, 1'b0, 8'h0);
        push_beat(17'h00050, 1'b0, 8'h0);
        push_exp(0, 1'b0, {56'h0, b0}, -1);
        push_exp(1, 1'b0, {56'h0, b1}, -1);
        fork
            do_req(0, 1'b0, 2'd0, 17'h00040, 64'h0);
            do_req(1, 1'b0, 2'd0, 17'h00050, 64'h0);
        join
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bus_valid", {63'h0, bus_valid}, 64'h0);
        chk("rst_bus_addr", {47'h0, bus_addr}, 64'h0);
        chk("rst_done", {62'h0, m0_done, m1_done}, 64'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 64'h0);
        chk("rst_gnt", {63'h0, gnt}, 64'h0);
        rst_n = 1'b1;

        // Single 1-byte read
        @(posedge clk); #1;
        rd_q.push_back(8'hA5);
        push_beat(17'h00010, 1'b0, 8'h0);
        push_exp(0, 1'b0, 64'hA5, cyc + 3);
        do_req(0, 1'b0, 2'd0, 17'h00010, 64'h0);

        // 8-byte write across the address wrap
        @(posedge clk); #1;
        push_beat(17'h1FFFE, 1'b1, 8'h11);
        push_beat(17'h1FFFF, 1'b1, 8'h22);
        push_beat(17'h00000, 1'b1, 8'h33);
        push_beat(17'h00001, 1'b1, 8'h44);
        push_beat(17'h00002, 1'b1, 8'h55);
        push_beat(17'h00003, 1'b1, 8'h66);
        push_beat(17'h00004, 1'b1, 8'h77);
        push_beat(17'h00005, 1'b1, 8'h88);
        push_exp(1, 1'b0, 64'h0, cyc + 10);
        do_req(1, 1'b1, 2'd3, 17'h1FFFE, 64'h8877665544332211);

        // Contention twice: grants 0,1,0,1
        contend(8'h11, 8'h22);
        contend(8'h33, 8'h44);

        // Wait states: 3 low cycles per byte
        @(posedge clk); #1;
        wait_n = 3;
        rd_q.push_back(8'h34);
        rd_q.push_back(8'h12);
        push_beat(17'h00100, 1'b0, 8'h0);
        push_beat(17'h00101, 1'b0, 8'h0);
        push_exp(0, 1'b0, 64'h1234, cyc + 10);
        do_req(0, 1'b0, 2'd1, 17'h00100, 64'h0);
        wait_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rdata_hold", m0_rdata, 64'h1234);
        chk("done_pulse_clear", {63'h0, m0_done}, 64'h0);

        // Timeout with bus_ready stuck low
        @(posedge clk); #1;
        stuck = 1'b1;
        bv_cnt = 0;
        push_exp(0, 1'b1, 64'h0, cyc + 6);
        do_req(0, 1'b0, 2'd2, 17'h00200, 64'h0);
        chk("timeout_valid_cycles", bv_cnt, 4);
        stuck = 1'b0;

        @(posedge clk); #1;
        rd_q.push_back(8'h7E);
        push_beat(17'h00300, 1'b0, 8'h0);
        push_exp(0, 1'b0, 64'h7E, cyc + 3);
        do_req(0, 1'b0, 2'd0, 17'h00300, 64'h0);

        // Reset during byte 2 of an 8-byte read
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) rd_q.push_back(8'(8'hC0 + i));
        push_beat(17'h00100, 1'b0, 8'h0);
        push_beat(17'h00101, 1'b0, 8'h0);
        m0_we = 1'b0; m0_size = 2'd3; m0_addr = 17'h00100; m0_req = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk); #1;
            seen = bus_valid && (bus_addr == 17'h00102);
        end
        chk("reached_byte2", {63'h0, seen}, 64'h1);
        #1;
        rst_n = 1'b0;
        m0_req = 1'b0;
        #1;
        chk("mid_rst_bus_valid", {63'h0, bus_valid}, 64'h0);
        chk("mid_rst_bus_addr", {47'h0, bus_addr}, 64'h0);
        chk("mid_rst_rdata", m0_rdata | m1_rdata, 64'h0);
        chk("mid_rst_gnt", {63'h0, gnt}, 64'h0);
        rd_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_beats_left", beat_q.size(), 0);
        beat_q.delete();
        contend(8'h5A, 8'hC3);

        for (int i = 0; i < 50 && (exp_q.size() != 0 || beat_q.size() != 0); i++)
            @(posedge clk);
        chk("exp_drained", exp_q.size(), 0);
        chk("beats_drained", beat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arb.md
Name: bus_arb

Overview:
- Shares the single 8-bit bus unit (17-bit byte address) between two requesters: port 0 is the control unit, port 1 is instruction fetch.
- Each request is a 1/2/4/8-byte little-endian read or write.
- The block sequences it as back-to-back byte accesses on the bus unit.
- For reads it assembles the bytes into a 64-bit result for the register bank.
- Two-way round-robin arbitration, one outstanding transaction total, per-byte timeout.

Parameters:
ADDR_W, 17, byte address width (bus unit address space)
TIMEOUT, 255, max cycles one byte may wait for bus_ready before abort; 0 = no timeout
TO_W, 8, timeout counter width; must satisfy TIMEOUT < 2**TO_W

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
m0_req  in  1  port 0 request; hold high with fields stable until m0_done
m0_we  in  1  port 0: 1 = write, 0 = read
m0_size  in  2  port 0 size: 0=1B, 1=2B, 2=4B, 3=8B
m0_addr  in  ADDR_W  port 0 base byte address
m0_wdata  in  64  port 0 write data, byte 0 = bits 7:0
m0_done  out  1  port 0 one-cycle completion pulse
m0_err  out  1  port 0 timeout flag, valid with m0_done
m0_rdata  out  64  port 0 read result, valid with m0_done
m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_done, m1_err, m1_rdata  same as port 0, for port 1
bus_valid  out  1  byte access in progress
bus_we  out  1  byte write strobe, valid while bus_valid
bus_addr  out  ADDR_W  byte address
bus_wdata  out  8  write byte
bus_rdata  in  8  read byte, sampled when bus_valid & bus_ready
bus_ready  in  1  bus unit completes current byte this cycle
gnt  out  1  owner of current or most recent transaction (0/1)

Behaviour:
- Reset (rst_n low, any time, including mid-transaction): state=IDLE; bus_valid=0, bus_we=0, bus_addr=0, bus_wdata=0; all done/err=0; all rdata=0; byte index=0; timeout count=0.
- Reset also sets last-grant pointer=1, so port 0 wins the first contention.
- All outputs are registered.
- IDLE:
  - Sample m0_req/m1_req at each edge.
  - One request high: grant that port.
  - Both high: grant the port not equal to last-grant.
  - On grant: latch we/size/addr/wdata, set gnt and last-grant, clear result, idx=0, go XFER.
- XFER:
  - Outputs are bus_valid=1, bus_addr=(base+idx) mod 2**ADDR_W, bus_we=latched we, and bus_wdata=latched wdata byte idx.
  - Address wraps from 0x1FFFF to 0x00000 silently.
  - Outputs hold until bus_valid & bus_ready at an edge.
  - On that edge, for a read, result byte idx <= bus_rdata.
  - If idx = nbytes-1 (nbytes = 1<<size), go DONE. Otherwise idx++ and stay in XFER; bus_valid stays high with the next address in the next cycle.
  - Every completed byte resets the timeout count.
- Timeout:
  - While bus_valid & !bus_ready, count++.
  - When count reaches TIMEOUT (TIMEOUT != 0), abort: go DONE with err=1 and rdata=0.
  - bus_valid drops at the next edge.
- DONE (exactly one cycle):
  - Granted port gets done=1, err as computed.
  - rdata = result, with bytes >= nbytes zero; rdata=0 on writes.
  - Other port's done=0.
  - bus_valid=0.
  - Next state IDLE.
- rdata holds until the next done on that port; done and err return to 0 after one cycle.
- Requester rule: req must be low at the edge that ends DONE. A req still high in IDLE is a new request.
- Latency, reads and writes: done is seen 2 + N cycles after the IDLE edge that samples req, where N = nbytes + total bus_ready wait cycles. No zero-wait bubbles between bytes.
- A request arriving while busy waits; it is granted at the first IDLE edge. A lone requester may be re-granted back-to-back.
- Change of m*_ fields during a transaction: ignored, since fields are latched at grant.
- size is decoded only at grant.

Test Plan:
- Single read: m0 read size=0 addr=0x00010, bus_rdata=0xA5, bus_ready always 1 -> one bus_valid cycle at 0x00010; m0_done 3 cycles after req sampled; m0_rdata=0x00000000000000A5; m0_err=0.
- 8-byte write, wrap: m1 write size=3 addr=0x1FFFE wdata=0x8877665544332211, bus_ready=1 -> bus_addr 0x1FFFE, 0x1FFFF, 0x00000..0x00005 with bus_wdata 0x11..0x88 on consecutive cycles; m1_done once; m1_rdata=0.
- Contention: m0 and m1 both request 1-byte reads from reset -> m0 served first, then m1. Repeat with both high again -> m0 is granted after m1, so grants alternate 0,1,0,1.
- Wait states: m0 read size=1, bus_ready low 3 cycles per byte, bytes 0x34 then 0x12 -> m0_rdata=0x1234; done 10 cycles after sampling.
- Timeout: TIMEOUT=4, bus_ready stuck low -> bus_valid high 4 cycles, then m0_done=1, m0_err=1, m0_rdata=0. Next request is served normally.
- Reset mid-XFER: assert rst_n low during byte 2 of an 8-byte read -> bus_valid=0 and all outputs 0 immediately. After release, m1 and m0 both request -> m0 is granted.
